sensor_debounce: RTL and testbench
==================================

// Module: sensor_debounce
// PURPOSE
//  Upstream conditioning stage for the warehouse-door control FSM.
//  Synchronises two raw limit/presence sensor inputs and debounces each one.
//  Emits clean levels that drive the FSM's S1/S2 inputs, one-cycle rise pulses,
//  and a conflict flag for the case where both sensors read active.
// PARAMETERS
//  DEBOUNCE_CYCLES  120000  stable-sample count before a level change is accepted (10 ms @ 12 MHz); >=2
//  STUCK_CYCLES     1200000 cycles a clean level may stay high before stuck fault (only with STUCK_DETECT_EN)
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst         in   1  synchronous, active-high reset
//  s1_raw      in   1  raw sensor 1, asynchronous, may bounce
//  s2_raw      in   1  raw sensor 2, asynchronous, may bounce
//  s1_clean    out  1  debounced sensor 1 level (feeds FSM S1)
//  s2_clean    out  1  debounced sensor 2 level (feeds FSM S2)
//  s1_rise     out  1  1-cycle pulse when s1_clean goes 0->1
//  s2_rise     out  1  1-cycle pulse when s2_clean goes 0->1
//  conflict    out  1  registered s1_clean & s2_clean
//  stuck_flt   out  1  sticky stuck-sensor fault (tied 0 without STUCK_DETECT_EN)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): sync FFs, counters and all outputs <= 0; channels -> LOW.
//    Reset mid-debounce aborts the count; clean outputs read 0 after that edge.
//  - Sync: 2-FF synchroniser per channel; debouncer sees sN_sync only.
//  - Per-channel FSM, counter cnt of width $clog2(DEBOUNCE_CYCLES):
//      LOW:       sync=1 -> CHK_HI, cnt<=0
//      CHK_HI:    sync=0 -> LOW (glitch rejected, clean unchanged);
//                 cnt==DEBOUNCE_CYCLES-1 -> HIGH, clean<=1; else cnt<=cnt+1
//      HIGH:      sync=0 -> CHK_LO, cnt<=0
//      CHK_LO:    sync=1 -> HIGH; cnt==DEBOUNCE_CYCLES-1 -> LOW, clean<=0; else cnt+1
//  - Latency: raw stable from before edge 0 -> clean changes at edge 2+DEBOUNCE_CYCLES.
//  - Any pulse shorter than DEBOUNCE_CYCLES synced samples never reaches clean.
//  - sN_rise high exactly the cycle after clean 0->1 (registered edge detect); never on fall.
//  - conflict: registered AND of clean levels, 1-cycle lag; channels remain independent,
//    simultaneous qualification on both is legal and sets both clean + conflict.
//  - Counter never wraps: saturates by leaving CHK_* at terminal count.
// CONFIGURATION
//  STUCK_DETECT_EN defined: per-channel high-time counter runs while clean=1, clears on
//    clean=0; reaching STUCK_CYCLES-1 sets stuck_flt (sticky until rst); clean unaffected.
//  STUCK_DETECT_EN undefined: no high-time counters; stuck_flt constant 0.
// STRUCTURE
//  Shared package/include: channel state encodings (LOW, CHK_HI, HIGH, CHK_LO, 2 bits)
//    and default timing constants for 12 MHz.
//  Sub-module debounce_channel (sync + FSM + counter + rise detect), instantiated twice;
//    top adds conflict register and optional stuck logic.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, STUCK_CYCLES=16)
//  1 s1_raw 0->1 held before edge 0 -> s1_clean=1 at edge 6, s1_rise=1 at edge 7 only.
//  2 s1_raw high 3 cycles then low -> s1_clean stays 0, s1_rise never fires.
//  3 s2_clean=1, s2_raw bounces 1-0-1 (1-cycle dips) for 10 cycles -> s2_clean stays 1.
//  4 both raw high same cycle -> both clean=1 at edge 6, conflict=1 at edge 7.
//  5 rst pulsed during CHK_HI (cnt=2) -> all outputs 0; new 4-sample count needed after rst.
//  6 STUCK_DETECT_EN: s1 held high -> stuck_flt=1 16 cycles after s1_clean rise, holds
//    after s1 drops; without macro stuck_flt=0 throughout.

Source files
------------

// File: rtl/sensor_debounce_pkg.sv
// Shared types and default timing for the sensor debounce stage.
// Defaults assume a 12 MHz system clock.
package sensor_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } ch_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;   // 10 ms
  localparam int unsigned DEF_STUCK_CYCLES    = 1200000;  // 100 ms
  localparam int unsigned NUM_CH              = 2;

  typedef struct packed {
    logic clean;
    logic rise;
  } ch_out_t;

  // The clean level is 1 in HIGH and while checking a possible fall.
  function automatic logic state_is_high(ch_state_e s);
    return (s == ST_HIGH) || (s == ST_CHK_LO);
  endfunction

endpackage

// File: rtl/sensor_debounce_channel.sv
// One sensor channel: 2-FF synchroniser, debounce FSM with a saturating
// stable-sample counter, and a registered rising-edge pulse.
module sensor_debounce_channel
  import sensor_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw,
  output ch_out_t out
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          sync;
  ch_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          clean, clean_q, rise;

  // sync_pipe[0] may go metastable; only sync_pipe[1] is used downstream
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], raw};
  end

  assign sync = sync_pipe[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Leaving CHK_* at terminal count is what keeps the counter from wrapping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_LOW: begin
        if (sync) begin
          state_nxt = ST_CHK_HI;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_HI: begin
        if (!sync)              state_nxt = ST_LOW;
        else if (cnt == CNT_TC) state_nxt = ST_HIGH;
        else                    cnt_nxt   = cnt + CW'(1);
      end
      ST_HIGH: begin
        if (!sync) begin
          state_nxt = ST_CHK_LO;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_LO: begin
        if (sync)               state_nxt = ST_HIGH;
        else if (cnt == CNT_TC) state_nxt = ST_LOW;
        else                    cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = ST_LOW;
    endcase
  end

  always_comb begin
    clean = state_is_high(state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clean_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      clean_q <= clean;
      rise    <= clean & ~clean_q;
    end
  end

  assign out.clean = clean;
  assign out.rise  = rise;

endmodule

// File: rtl/sensor_debounce.sv
// Two-channel sensor conditioning: debounced levels, rise pulses, conflict
// flag and optional stuck-high fault (enabled by defining STUCK_DETECT_EN).
module sensor_debounce
  import sensor_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic s1_raw,
  input  logic s2_raw,
  output logic s1_clean,
  output logic s2_clean,
  output logic s1_rise,
  output logic s2_rise,
  output logic conflict,
  output logic stuck_flt
);

  logic    [NUM_CH-1:0] ch_raw;
  logic    [NUM_CH-1:0] ch_clean;
  ch_out_t [NUM_CH-1:0] ch_out;
  logic                 conflict_q;

  assign ch_raw = {s2_raw, s1_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .raw (ch_raw[i]),
      .out (ch_out[i])
    );
    assign ch_clean[i] = ch_out[i].clean;
  end

  assign s1_clean = ch_out[0].clean;
  assign s2_clean = ch_out[1].clean;
  assign s1_rise  = ch_out[0].rise;
  assign s2_rise  = ch_out[1].rise;

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= &ch_clean;
  end

  assign conflict = conflict_q;

`ifdef STUCK_DETECT_EN
  localparam int unsigned HW = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
  localparam logic [HW-1:0] HI_TC = HW'(STUCK_CYCLES - 1);

  logic [NUM_CH-1:0] hi_hit;
  logic              stuck_q;

  // High-time counters saturate at terminal count; the fault itself is sticky
  for (genvar i = 0; i < NUM_CH; i++) begin : g_hi
    logic [HW-1:0] hi_cnt;

    always_ff @(posedge clk) begin
      if (rst || !ch_clean[i])  hi_cnt <= '0;
      else if (hi_cnt != HI_TC) hi_cnt <= hi_cnt + HW'(1);
    end

    assign hi_hit[i] = ch_clean[i] && (hi_cnt == HI_TC);
  end

  always_ff @(posedge clk) begin
    if (rst)          stuck_q <= 1'b0;
    else if (|hi_hit) stuck_q <= 1'b1;
  end

  assign stuck_flt = stuck_q;
`else
  logic stuck_cfg_unused;
  assign stuck_cfg_unused = (STUCK_CYCLES != 0);
  assign stuck_flt        = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: directed scenarios with literal expectations plus
// randomized bouncing inputs compared every cycle against a behavioural model.
module tb_sensor_debounce;

  localparam int D = 4;
  localparam int S = 16;
`ifdef STUCK_DETECT_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk, rst, s1_raw, s2_raw;
  logic s1_clean, s2_clean, s1_rise, s2_rise, conflict, stuck_flt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: raw delay line, window of samples seen by the debouncer,
  // and the expected outputs.
  bit [1:0] d0, d1;
  bit [1:0] hist[$];
  bit [1:0] m_clean, m_prev, m_rise;
  bit       m_conf, m_stuck;
  int       ht[2];

  sensor_debounce #(
    .DEBOUNCE_CYCLES(D),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s1_raw   (s1_raw),
    .s2_raw   (s2_raw),
    .s1_clean (s1_clean),
    .s2_clean (s2_clean),
    .s1_rise  (s1_rise),
    .s2_rise  (s2_rise),
    .conflict (conflict),
    .stuck_flt(stuck_flt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // A level is accepted once D+1 consecutive debouncer samples disagree with it.
  task automatic model_step();
    bit [1:0] raw_v, seen, old_clean;
    bit       all_diff;
    raw_v = {s2_raw, s1_raw};
    if (rst) begin
      d0 = '0; d1 = '0; hist.delete();
      m_clean = '0; m_prev = '0; m_rise = '0;
      m_conf = 1'b0; m_stuck = 1'b0; ht[0] = 0; ht[1] = 0;
      return;
    end
    seen = d1; d1 = d0; d0 = raw_v;
    hist.push_back(seen);
    if (hist.size() > D + 1) void'(hist.pop_front());
    old_clean = m_clean;
    for (int c = 0; c < 2; c++) begin
      if (hist.size() == D + 1) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i][c] == old_clean[c]) all_diff = 1'b0;
        if (all_diff) m_clean[c] = ~old_clean[c];
      end
      ht[c] = old_clean[c] ? ht[c] + 1 : 0;
      if (STK && ht[c] >= S) m_stuck = 1'b1;
    end
    m_rise = old_clean & ~m_prev;
    m_prev = old_clean;
    m_conf = &old_clean;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check1("s1_clean", s1_clean, m_clean[0]);
      check1("s2_clean", s2_clean, m_clean[1]);
      check1("s1_rise", s1_rise, m_rise[0]);
      check1("s2_rise", s2_rise, m_rise[1]);
      check1("conflict", conflict, m_conf);
      check1("stuck_flt", stuck_flt, m_stuck);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int hold[2];
    bit [1:0] rv;

    rst = 1'b1; s1_raw = 1'b0; s2_raw = 1'b0;
    step(); step();
    chk_en = 1'b1;
    check1("rst_s1_clean", s1_clean, 1'b0);
    check1("rst_s2_clean", s2_clean, 1'b0);
    check1("rst_s1_rise", s1_rise, 1'b0);
    check1("rst_s2_rise", s2_rise, 1'b0);
    check1("rst_conflict", conflict, 1'b0);
    check1("rst_stuck", stuck_flt, 1'b0);
    rst = 1'b0;
    repeat (4) step();

    // Clean qualification latency and single rise pulse
    s1_raw = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check1("t1_clean", s1_clean, k >= 6);
      check1("t1_rise", s1_rise, k == 7);
    end

    // Short pulse rejected
    s1_raw = 1'b0;
    repeat (10) step();
    s1_raw = 1'b1;
    repeat (3) step();
    s1_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check1("t2_clean", s1_clean, 1'b0);
      check1("t2_rise", s1_rise, 1'b0);
    end

    // Single-cycle dips while high do not drop the level
    s2_raw = 1'b1;
    repeat (8) step();
    check1("t3_pre_clean", s2_clean, 1'b1);
    for (int k = 0; k < 10; k++) begin
      s2_raw = (k % 2 == 1);
      step();
      check1("t3_clean", s2_clean, 1'b1);
      check1("t3_rise", s2_rise, 1'b0);
    end

    // Both channels qualify together
    rst = 1'b1; s1_raw = 1'b0; s2_raw = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    s1_raw = 1'b1; s2_raw = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check1("t4_s1_clean", s1_clean, k >= 6);
      check1("t4_s2_clean", s2_clean, k >= 6);
      check1("t4_conflict", conflict, k >= 7);
    end

    // Reset mid-count, then requalify; stuck fault while held high
    rst = 1'b1; s1_raw = 1'b0; s2_raw = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    s1_raw = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      rst = (k == 5);
      step();
      if (k == 5) begin
        check1("t5_s1_clean", s1_clean, 1'b0);
        check1("t5_s1_rise", s1_rise, 1'b0);
        check1("t5_conflict", conflict, 1'b0);
        check1("t5_stuck", stuck_flt, 1'b0);
      end else begin
        check1("t5_requal", s1_clean, k >= 12);
        check1("t6_stuck", stuck_flt, STK && (k >= 28));
      end
    end
    rst = 1'b0;
    s1_raw = 1'b0;
    repeat (12) step();
    check1("t6_s1_dropped", s1_clean, 1'b0);
    check1("t6_stuck_hold", stuck_flt, STK);

    // Randomized bouncing with occasional resets
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold[0] = 0; hold[1] = 0;
    rv = '0;
    repeat (3000) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          rv[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30))
                                                : int'($urandom_range(1, 6));
        end
        hold[c]--;
      end
      s1_raw = rv[0];
      s2_raw = rv[1];
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
